serial_addsub: RTL and testbench

//  Parametrised bit-serial adder/subtractor. It processes DIGIT bits per clock through a decoder-based

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_bit_cell.sv | 28 ++
 rtl/serial_addsub.sv | 125 ++++++++++++
 tb/tb_serial_addsub.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encoding and mode constants for the serial add/sub unit
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_bit_cell.sv
// rtl/addsub_bit_cell.sv - one-bit full add/sub cell built from a 3-to-8 minterm decoder
module addsub_bit_cell
  import addsub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic c,
  input  logic m,
  output logic s,
  output logic co
);

  logic [7:0] w_mt;
  logic       w_carry;
  logic       w_borrow;

  // Minterm index is {x, y, c}
  always_comb begin
    w_mt = 8'd0;
    w_mt[{x, y, c}] = 1'b1;
  end

  assign s        = w_mt[1] | w_mt[2] | w_mt[4] | w_mt[7];
  assign w_carry  = w_mt[3] | w_mt[5] | w_mt[6] | w_mt[7];
  assign w_borrow = w_mt[1] | w_mt[2] | w_mt[3] | w_mt[7];
  assign co       = (m == MODE_SUB) ? w_borrow : w_carry;

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial adder/subtractor with valid/ready handshake and overflow flag
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cbin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cbout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic                   r_mode;
  logic                   r_cb;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_res;
  logic                   r_cbout;
  logic                   r_ovf;

  logic [DIGIT:0]         w_c;
  logic [DIGIT-1:0]       w_s;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic                   w_accept;
  logic                   w_last;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE) && !rst;
    out_valid = (r_state == ST_DONE);
  end

  assign w_c[0] = r_cb;

  generate
    for (genvar g = 0; g < DIGIT; g++) begin : g_cell
      addsub_bit_cell u_cell (
        .x  (r_a[g]),
        .y  (r_b[g]),
        .c  (w_c[g]),
        .m  (r_mode),
        .s  (w_s[g]),
        .co (w_c[g+1])
      );
    end
  endgenerate

  // New digit enters at the MSB end so the LSB digit lands at bit 0 after NDIG shifts
  assign w_cat = {w_s, r_res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= MODE_ADD;
      r_cb    <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_cbout <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_mode <= mode;
      r_cb   <= cbin;
      r_cnt  <= '0;
    end else if (r_state == ST_RUN) begin
      r_a   <= r_a >> DIGIT;
      r_b   <= r_b >> DIGIT;
      r_res <= w_cat[WIDTH+DIGIT-1:DIGIT];
      r_cb  <= w_c[DIGIT];
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_cbout <= w_c[DIGIT];
        r_ovf   <= w_c[DIGIT] ^ w_c[DIGIT-1];
      end
    end
  end

  assign result = r_res;
  assign cbout  = r_cbout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (W=8/D=1 and W=4/D=2 instances)
module tb_serial_addsub;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v8_in_valid = 0, v8_out_ready = 0, v8_cbin = 0, v8_mode = 0;
  logic [7:0] v8_a = 0, v8_b = 0;
  logic       v8_in_ready, v8_out_valid, v8_cbout, v8_ovf;
  logic [7:0] v8_result;

  logic       v4_in_valid = 0, v4_out_ready = 0, v4_cbin = 0, v4_mode = 0;
  logic [3:0] v4_a = 0, v4_b = 0;
  logic       v4_in_ready, v4_out_valid, v4_cbout, v4_ovf;
  logic [3:0] v4_result;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .a(v8_a), .b(v8_b), .cbin(v8_cbin), .mode(v8_mode),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready),
    .result(v8_result), .cbout(v8_cbout), .ovf(v8_ovf)
  );

  serial_addsub #(.WIDTH(4), .DIGIT(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
    .a(v4_a), .b(v4_b), .cbin(v4_cbin), .mode(v4_mode),
    .out_valid(v4_out_valid), .out_ready(v4_out_ready),
    .result(v4_result), .cbout(v4_cbout), .ovf(v4_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views of the operands
  task automatic model(input int w, input int a, input int b, input int cbin, input int mode,
                       output int res, output int cb, output int ov);
    int full, sa, sb, sfull, half;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - 2 * half : a;
    sb = (b >= half) ? b - 2 * half : b;
    if (mode == 0) begin
      full  = a + b + cbin;
      sfull = sa + sb + cbin;
      cb    = (full >> w) & 1;
    end else begin
      full  = a - b - cbin;
      sfull = sa - sb - cbin;
      cb    = (a < b + cbin) ? 1 : 0;
    end
    res = full & ((1 << w) - 1);
    ov  = (sfull > half - 1 || sfull < -half) ? 1 : 0;
  endtask

  function automatic int sel_ov(input bit w4);
    return w4 ? int'(v4_out_valid) : int'(v8_out_valid);
  endfunction
  function automatic int sel_ir(input bit w4);
    return w4 ? int'(v4_in_ready) : int'(v8_in_ready);
  endfunction
  function automatic int sel_res(input bit w4);
    return w4 ? int'(v4_result) : int'(v8_result);
  endfunction
  function automatic int sel_cb(input bit w4);
    return w4 ? int'(v4_cbout) : int'(v8_cbout);
  endfunction
  function automatic int sel_ovf(input bit w4);
    return w4 ? int'(v4_ovf) : int'(v8_ovf);
  endfunction

  task automatic drive(input bit w4, input bit vld, input int a, input int b, input int cbin, input int mode);
    if (w4) begin
      v4_in_valid = vld; v4_a = a[3:0]; v4_b = b[3:0]; v4_cbin = cbin[0]; v4_mode = mode[0];
    end else begin
      v8_in_valid = vld; v8_a = a[7:0]; v8_b = b[7:0]; v8_cbin = cbin[0]; v8_mode = mode[0];
    end
  endtask

  task automatic set_ordy(input bit w4, input bit v);
    if (w4) v4_out_ready = v;
    else    v8_out_ready = v;
  endtask

  // Accept one op, measure latency, compare against expected values, then drain it
  task automatic do_op(input bit w4, input int a, input int b, input int cbin, input int mode,
                       input int e_res, input int e_cb, input int e_ov, input string tag);
    int lat;
    @(negedge clk);
    drive(w4, 1'b1, a, b, cbin, mode);
    chk({tag, " in_ready_idle"}, sel_ir(w4), 1);
    @(posedge clk); #1;
    drive(w4, 1'b0, 0, 0, 0, 0);
    lat = 0;
    while (sel_ov(w4) == 0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, w4 ? 2 : 8);
    chk({tag, " result"}, sel_res(w4), e_res);
    chk({tag, " cbout"}, sel_cb(w4), e_cb);
    chk({tag, " ovf"}, sel_ovf(w4), e_ov);
    chk({tag, " in_ready_done"}, sel_ir(w4), 0);
    set_ordy(w4, 1'b1);
    @(posedge clk); #1;
    set_ordy(w4, 1'b0);
    chk({tag, " out_valid_drop"}, sel_ov(w4), 0);
    chk({tag, " in_ready_back"}, sel_ir(w4), 1);
  endtask

  typedef struct {
    int mode; int a; int b; int cbin; int res; int cb; int ov;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int r, c, o, hold_res;

    vecs[0] = '{1, 'h05, 'h03, 0, 'h02, 0, 0};
    vecs[1] = '{1, 'h00, 'h01, 0, 'hFF, 1, 0};
    vecs[2] = '{1, 'h80, 'h01, 0, 'h7F, 0, 1};
    vecs[3] = '{0, 'hFF, 'h01, 0, 'h00, 1, 0};
    vecs[4] = '{0, 'h7F, 'h01, 0, 'h80, 0, 1};
    vecs[5] = '{0, 'h80, 'h80, 0, 'h00, 1, 1};
    vecs[6] = '{1, 'h7F, 'hFF, 0, 'h80, 1, 1};
    vecs[7] = '{0, 'h01, 'h01, 1, 'h03, 0, 0};
    vecs[8] = '{1, 'h00, 'h00, 1, 'hFF, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready8", int'(v8_in_ready), 0);
    chk("rst out_valid8", int'(v8_out_valid), 0);
    chk("rst result8", int'(v8_result), 0);
    chk("rst cbout8", int'(v8_cbout), 0);
    chk("rst ovf8", int'(v8_ovf), 0);
    chk("rst in_ready4", int'(v4_in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst in_ready8", int'(v8_in_ready), 1);

    foreach (vecs[i])
      do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].cbin, vecs[i].mode,
            vecs[i].res, vecs[i].cb, vecs[i].ov, $sformatf("vec%0d", i));

    // Backpressure: hold out_ready low in DONE while wiggling the inputs
    @(negedge clk);
    drive(1'b0, 1'b1, 'h12, 'h34, 0, 0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("bp out_valid_rise", int'(v8_out_valid), 1);
    hold_res = int'(v8_result);
    chk("bp result", hold_res, 'h46);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, k[0], int'($urandom_range(0, 255)), 'h55, 1, 1);
      @(posedge clk); #1;
      chk($sformatf("bp%0d out_valid", k), int'(v8_out_valid), 1);
      chk($sformatf("bp%0d in_ready", k), int'(v8_in_ready), 0);
      chk($sformatf("bp%0d result", k), int'(v8_result), 'h46);
      chk($sformatf("bp%0d cbout", k), int'(v8_cbout), 0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    v8_out_ready = 1'b1;
    @(posedge clk); #1;
    v8_out_ready = 1'b0;
    chk("bp out_valid_drop", int'(v8_out_valid), 0);

    // Reset three cycles into RUN aborts the op
    @(negedge clk);
    drive(1'b0, 1'b1, 'h0F, 'h01, 0, 0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst in_ready", int'(v8_in_ready), 0);
    chk("midrst result", int'(v8_result), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst in_ready_after", int'(v8_in_ready), 1);
    begin
      int seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        if (v8_out_valid) seen = 1;
      end
      chk("midrst no_out_valid", seen, 0);
    end
    do_op(1'b0, 'h0F, 'h01, 0, 0, 'h10, 0, 0, "after_rst");

    for (int k = 0; k < 150; k++) begin
      int ra, rb, rc, rm;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      rc = int'($urandom_range(0, 1));
      rm = int'($urandom_range(0, 1));
      model(8, ra, rb, rc, rm, r, c, o);
      do_op(1'b0, ra, rb, rc, rm, r, c, o, $sformatf("rnd%0d", k));
    end

    for (int m = 0; m < 2; m++)
      for (int ci = 0; ci < 2; ci++)
        for (int ea = 0; ea < 16; ea++)
          for (int eb = 0; eb < 16; eb++) begin
            model(4, ea, eb, ci, m, r, c, o);
            do_op(1'b1, ea, eb, ci, m, r, c, o,
                  $sformatf("w4 m%0d c%0d a%0h b%0h", m, ci, ea, eb));
          end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
